// File: rtl/sm2c_rr_sched.sv
// sm2c_rr_sched: round-robin scheduler sharing one sign-magnitude to
// two's-complement converter among N_REQ sources, with burst lock and a
// single registered output stage tagged with the source index.
// Optional macro SM2C_SCHED_NZ_CNT_EN enables the negative-zero counter o_nz_cnt;
// when undefined o_nz_cnt is tied to zero.
module sm2c_rr_sched #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned ID_W   = $clog2(N_REQ)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [N_REQ-1:0]          i_req_valid,
   input  logic [N_REQ-1:0]          i_req_last,
   input  logic [N_REQ*DATA_W-1:0]   i_req_data,
   output logic [N_REQ-1:0]          o_req_ready,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [DATA_W-1:0]         o_data,
   output logic [ID_W-1:0]           o_id,
   output logic                      o_last,
   output logic [15:0]               o_nz_cnt
);

   typedef enum logic {ST_ARB, ST_BURST} state_t;

   state_t            state;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   lock_id;
   logic              load;
   logic              accept;
   logic [N_REQ-1:0]  grant;
   logic [ID_W-1:0]   grant_id;
   logic [ID_W-1:0]   next_ptr;
   logic [DATA_W-1:0] sel_data;
   logic [DATA_W-1:0] conv_data;
   logic              sel_last;

   // No grants while the output register is stalled or reset is asserted.
   assign load = (~o_valid | i_ready) & ~i_rst;

   // Grant selection: locked requester in BURST, rotating priority from ptr in ARB.
   always_comb begin
      int unsigned cand;
      logic [ID_W-1:0] cand_id;
      grant    = '0;
      grant_id = '0;
      cand     = 0;
      cand_id  = '0;
      if (load) begin
         if (state == ST_BURST) begin
            if (i_req_valid[lock_id]) begin
               grant[lock_id] = 1'b1;
               grant_id       = lock_id;
            end
         end else begin
            // Walk offsets from farthest to nearest so the nearest valid one wins last.
            for (int unsigned k = N_REQ; k > 0; k--) begin
               cand    = (32'(ptr) + k - 1) % N_REQ;
               cand_id = ID_W'(cand);
               if (i_req_valid[cand_id]) begin
                  grant          = '0;
                  grant[cand_id] = 1'b1;
                  grant_id       = cand_id;
               end
            end
         end
      end
   end

   assign o_req_ready = grant;
   assign accept      = |grant;
   assign sel_data    = i_req_data[32'(grant_id)*DATA_W +: DATA_W];
   assign sel_last    = i_req_last[grant_id];
   assign next_ptr    = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

   // Negative zero yields 0 - 0 = 0, so no special case is needed here.
   assign conv_data = sel_data[DATA_W-1] ? ('0 - {1'b0, sel_data[DATA_W-2:0]}) : sel_data;

   // Arbitration FSM and registered output stage.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= ST_ARB;
         ptr     <= '0;
         lock_id <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_id    <= '0;
         o_last  <= 1'b0;
      end else if (load) begin
         o_valid <= accept;
         if (accept) begin
            o_data <= conv_data;
            o_id   <= grant_id;
            o_last <= sel_last;
            if (sel_last) begin
               state <= ST_ARB;
               ptr   <= next_ptr;
            end else begin
               state   <= ST_BURST;
               lock_id <= grant_id;
            end
         end
      end
   end

`ifdef SM2C_SCHED_NZ_CNT_EN
   logic        sel_nz;
   logic [15:0] nz_cnt;

   assign sel_nz = sel_data[DATA_W-1] & ~|sel_data[DATA_W-2:0];

   // Saturating count of accepted negative-zero beats.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         nz_cnt <= '0;
      end else if (accept && sel_nz && nz_cnt != '1) begin
         nz_cnt <= nz_cnt + 1'b1;
      end
   end

   assign o_nz_cnt = nz_cnt;
`else
   assign o_nz_cnt = '0;
`endif

endmodule
